// File: rtl/hmm_pkg.sv
// Shared HMM-Viterbi datapath definitions: default operand/result widths,
// the feature-vector length and the row scheduler state encoding.
package hmm_pkg;
  localparam int HMM_VEC_LEN = 13;
  localparam int HMM_A_W     = 17;
  localparam int HMM_B_W     = 14;
  localparam int HMM_S_W     = 23;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/mac_row_sched_if.sv
// Job control, operand memory and result bus of the MAC row scheduler.
// master = host/memory side, slave = the scheduler.
interface mac_row_sched_if #(
  parameter int ROW_W = 6,
  parameter int IDX_W = 4,
  parameter int WA_W  = 10,
  parameter int A_W   = hmm_pkg::HMM_A_W,
  parameter int B_W   = hmm_pkg::HMM_B_W,
  parameter int S_W   = hmm_pkg::HMM_S_W
);
  logic                    start;
  logic [ROW_W-1:0]        n_rows;
  logic                    busy;
  logic                    done;
  logic [IDX_W-1:0]        x_addr;
  logic signed [A_W-1:0]   x_data;
  logic [WA_W-1:0]         w_addr;
  logic signed [B_W-1:0]   w_data;
  logic                    res_valid;
  logic [ROW_W-1:0]        res_row;
  logic signed [S_W-1:0]   res;

  modport master (
    output start, n_rows, x_data, w_data,
    input  busy, done, x_addr, w_addr, res_valid, res_row, res
  );

  modport slave (
    input  start, n_rows, x_data, w_data,
    output busy, done, x_addr, w_addr, res_valid, res_row, res
  );
endinterface

// File: rtl/mac_row_sched_mac.sv
// MultAccum: signed multiply-accumulate, low S_W bits, two's-complement wrap.
// sclr takes effect only together with ce. s lags the ce cycle by LAT.
module MultAccum #(
  parameter int A_W = hmm_pkg::HMM_A_W,
  parameter int B_W = hmm_pkg::HMM_B_W,
  parameter int S_W = hmm_pkg::HMM_S_W,
  parameter int LAT = 1
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic                  sclr,
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  output logic signed [S_W-1:0] s
);
  logic signed [S_W-1:0] prod;
  logic signed [S_W-1:0] acc;

  // operands widened to S_W first so the product is already the low S_W bits
  assign prod = S_W'(a) * S_W'(b);

  // accumulator: clear or accumulate on ce
  always_ff @(posedge clk) begin
    if (ce) acc <= sclr ? '0 : acc + prod;
  end

  generate
    if (LAT == 1) begin : g_direct
      assign s = acc;
    end else begin : g_dly
      logic signed [S_W-1:0] dly [LAT-1];
      // extra output stages to model deeper MAC latency
      always_ff @(posedge clk) begin
        dly[0] <= acc;
        for (int k = 1; k < LAT-1; k++) dly[k] <= dly[k-1];
      end
      assign s = dly[LAT-2];
    end
  endgenerate
endmodule

// File: rtl/mac_row_sched.sv
// Row scheduler for MultAccum: n_rows dot products of x against consecutive
// row-major weight rows, one scored result per row.
module mac_row_sched
  import hmm_pkg::*;
#(
  parameter int VEC_LEN = HMM_VEC_LEN,
  parameter int ROW_W   = 6,
  parameter int IDX_W   = 4,
  parameter int WA_W    = 10,
  parameter int A_W     = HMM_A_W,
  parameter int B_W     = HMM_B_W,
  parameter int S_W     = HMM_S_W,
  parameter int MAC_LAT = 1
) (
  input logic             clk,
  input logic             sclr,
  mac_row_sched_if.slave  bus
);
  localparam int             D_W    = $clog2(MAC_LAT + 1);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(VEC_LEN - 1);
  localparam logic [D_W-1:0]   D_LAST = D_W'(MAC_LAT);

  state_t                state, nxt;
  logic [IDX_W-1:0]      i;
  logic [D_W-1:0]        d;
  logic [ROW_W-1:0]      row, nrows;
  logic [WA_W-1:0]       base;
  logic                  vld_pipe;  // fetch-valid delayed by the memory read latency
  logic                  fetch, clr, row_more;
  logic                  mac_ce, mac_sclr;
  logic signed [A_W-1:0] mac_a;
  logic signed [B_W-1:0] mac_b;
  logic signed [S_W-1:0] mac_s;

  assign fetch    = (state == ST_FETCH);
  assign clr      = (state == ST_CLR);
  assign row_more = ({1'b0, row} + 1'b1) < {1'b0, nrows};

  assign bus.busy   = clr || fetch || (state == ST_DRAIN);
  assign bus.done   = (state == ST_DONE);
  assign bus.x_addr = fetch ? i : '0;
  assign bus.w_addr = fetch ? base + WA_W'(i) : '0;

  // reset also empties the accumulator, so sclr rides along with ce
  assign mac_sclr = sclr || clr;
  assign mac_ce   = sclr || clr || vld_pipe;
  assign mac_a    = vld_pipe ? bus.x_data : '0;
  assign mac_b    = vld_pipe ? bus.w_data : '0;

  MultAccum #(.A_W(A_W), .B_W(B_W), .S_W(S_W), .LAT(MAC_LAT)) u_mac (
    .clk (clk), .ce (mac_ce), .sclr (mac_sclr), .a (mac_a), .b (mac_b), .s (mac_s)
  );

  // state register
  always_ff @(posedge clk) begin
    if (sclr) state <= ST_IDLE;
    else      state <= nxt;
  end

  // next state; start is honoured in IDLE and DONE so jobs chain without a gap
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) nxt = (bus.n_rows == '0) ? ST_DONE : ST_CLR;
        else           nxt = ST_IDLE;
      end
      ST_CLR:   nxt = ST_FETCH;
      ST_FETCH: if (i == I_LAST) nxt = ST_DRAIN;
      // DRAIN covers the last delayed operand plus MAC_LAT settle cycles
      ST_DRAIN: if (d == D_LAST) nxt = row_more ? ST_CLR : ST_DONE;
      default:  nxt = ST_IDLE;
    endcase
  end

  // counters, w base accumulator, ce pipe and result capture
  always_ff @(posedge clk) begin
    if (sclr) begin
      i             <= '0;
      d             <= '0;
      row           <= '0;
      nrows         <= '0;
      base          <= '0;
      vld_pipe      <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_row   <= '0;
      bus.res       <= '0;
    end else begin
      vld_pipe      <= fetch;
      bus.res_valid <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            nrows <= bus.n_rows;
            row   <= '0;
            base  <= '0;
          end
        end
        ST_CLR: begin
          i <= '0;
          d <= '0;
        end
        ST_FETCH: i <= i + 1'b1;
        ST_DRAIN: begin
          d <= d + 1'b1;
          if (d == D_LAST) begin
            bus.res       <= mac_s;
            bus.res_row   <= row;
            bus.res_valid <= 1'b1;
            if (row_more) begin
              row  <= row + 1'b1;
              base <= base + WA_W'(VEC_LEN);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
